// File: rtl/jpeg_rgb565_packer.sv
// jpeg_rgb565_packer
// Pops 24-bit RGB pixels from the JPEG output FIFO, converts each one to
// RGB565 and packs two pixels per 32-bit word (pixel 0 in [15:0]). Words go
// out on a registered valid/accept stream. The block also handles odd-length
// frames, synchronous flush and per-frame word counting.
// Optional build macro: JPEG_RGB565_ROUND_EN selects round-to-nearest with
// saturation instead of plain truncation. Timing is identical either way.
module jpeg_rgb565_packer #(
  parameter int COUNT_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               pixel_valid_i,
  input  logic [23:0]        pixel_data_i,
  input  logic               pixel_last_i,
  output logic               pixel_pop_o,
  input  logic               flush_i,
  output logic               out_valid_o,
  output logic [31:0]        out_data_o,
  output logic [3:0]         out_strb_o,
  output logic               out_last_o,
  input  logic               out_accept_i,
  output logic               frame_done_o,
  output logic [COUNT_W-1:0] word_count_o
);

  logic [4:0]         w_r5;
  logic [5:0]         w_g6;
  logic [4:0]         w_b5;
  logic [15:0]        w_px565;
  logic               w_slot_free;
  logic               w_accept;

  logic               r_have_lo;
  logic [15:0]        r_lo;
  logic               r_valid;
  logic [31:0]        r_data;
  logic [3:0]         r_strb;
  logic               r_last;
  logic               r_frame_done;
  logic [COUNT_W-1:0] r_count;

`ifdef JPEG_RGB565_ROUND_EN
  logic [8:0] w_r9;
  logic [8:0] w_g9;
  logic [8:0] w_b9;

  // Round to nearest; a carry into bit 8 means the result would overflow, so saturate
  always_comb begin
    w_r9 = {1'b0, pixel_data_i[23:16]} + 9'd4;
    w_g9 = {1'b0, pixel_data_i[15:8]}  + 9'd2;
    w_b9 = {1'b0, pixel_data_i[7:0]}   + 9'd4;
    w_r5 = w_r9[8] ? 5'd31 : 5'(w_r9 >> 3);
    w_g6 = w_g9[8] ? 6'd63 : 6'(w_g9 >> 2);
    w_b5 = w_b9[8] ? 5'd31 : 5'(w_b9 >> 3);
  end
`else
  // Plain truncation: keep the top bits of each channel
  always_comb begin
    w_r5 = 5'(pixel_data_i[23:16] >> 3);
    w_g6 = 6'(pixel_data_i[15:8]  >> 2);
    w_b5 = 5'(pixel_data_i[7:0]   >> 3);
  end
`endif

  assign w_px565     = {w_r5, w_g6, w_b5};
  assign w_slot_free = ~r_valid | out_accept_i;
  assign w_accept    = r_valid & out_accept_i;

  // A non-last pixel with nothing held only goes into lo, so it never needs the output slot
  assign pixel_pop_o = rst_ni & ~flush_i & pixel_valid_i &
                       ((~r_have_lo & ~pixel_last_i) | w_slot_free);

  assign out_valid_o  = r_valid;
  assign out_data_o   = r_data;
  assign out_strb_o   = r_strb;
  assign out_last_o   = r_last;
  assign frame_done_o = r_frame_done;
  assign word_count_o = r_count;

  // Packing, output register, word counting and frame-done pulse
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_have_lo    <= 1'b0;
      r_lo         <= '0;
      r_valid      <= 1'b0;
      r_data       <= '0;
      r_strb       <= '0;
      r_last       <= 1'b0;
      r_frame_done <= 1'b0;
      r_count      <= '0;
    end else if (flush_i) begin
      // Any held pixel and pending word are dropped; an accept this cycle is ignored
      r_have_lo    <= 1'b0;
      r_valid      <= 1'b0;
      r_strb       <= '0;
      r_last       <= 1'b0;
      r_frame_done <= 1'b0;
      r_count      <= '0;
    end else begin
      r_frame_done <= 1'b0;
      if (w_accept) begin
        r_valid <= 1'b0;
        if (r_last) begin
          r_count      <= '0;
          r_frame_done <= 1'b1;
        end else begin
          r_count <= r_count + 1'b1;
        end
      end
      if (pixel_pop_o) begin
        if (r_have_lo) begin
          r_data    <= {w_px565, r_lo};
          r_strb    <= 4'hF;
          r_last    <= pixel_last_i;
          r_valid   <= 1'b1;
          r_have_lo <= 1'b0;
        end else if (pixel_last_i) begin
          r_data  <= {16'h0000, w_px565};
          r_strb  <= 4'h3;
          r_last  <= 1'b1;
          r_valid <= 1'b1;
        end else begin
          r_lo      <= w_px565;
          r_have_lo <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_jpeg_rgb565_packer.sv
// Directed testbench for jpeg_rgb565_packer. Inputs change 1 ns after the
// rising edge; all DUT outputs are sampled on the falling edge.
module tb_jpeg_rgb565_packer;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        pixel_valid_i;
  logic [23:0] pixel_data_i;
  logic        pixel_last_i;
  logic        pixel_pop_o;
  logic        flush_i;
  logic        out_valid_o;
  logic [31:0] out_data_o;
  logic [3:0]  out_strb_o;
  logic        out_last_o;
  logic        out_accept_i;
  logic        frame_done_o;
  logic [15:0] word_count_o;

  int checks = 0;
  int fails  = 0;

  // Pixel source: a small array drained on every pop
  logic [23:0] src_data [16];
  logic        src_last [16];
  int          src_len;
  int          src_idx;
  int          pop_cnt;
  int          done_cnt;

  // Words accepted by the downstream side
  logic [31:0] cap_data  [$];
  logic [3:0]  cap_strb  [$];
  logic        cap_last  [$];
  logic [15:0] cap_count [$];

  jpeg_rgb565_packer #(.COUNT_W(16)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .pixel_valid_i(pixel_valid_i),
    .pixel_data_i (pixel_data_i),
    .pixel_last_i (pixel_last_i),
    .pixel_pop_o  (pixel_pop_o),
    .flush_i      (flush_i),
    .out_valid_o  (out_valid_o),
    .out_data_o   (out_data_o),
    .out_strb_o   (out_strb_o),
    .out_last_o   (out_last_o),
    .out_accept_i (out_accept_i),
    .frame_done_o (frame_done_o),
    .word_count_o (word_count_o)
  );

  always #5 clk_i = ~clk_i;

  // Pixel n has every channel's dropped LSBs at zero, so truncation and rounding agree
  function automatic logic [23:0] px(input int n);
    logic [7:0] c8;
    logic [7:0] c4;
    c8 = 8'(n * 8);
    c4 = 8'(n * 4);
    return {c8, c4, c8};
  endfunction

  task automatic load_src(input int first_n, input int count, input bit last_on_end);
    for (int i = 0; i < count; i++) begin
      src_data[i] = px(first_n + i);
      src_last[i] = last_on_end && (i == count - 1);
    end
    src_len = count;
    src_idx = 0;
  endtask

  task automatic clear_caps();
    cap_data.delete();
    cap_strb.delete();
    cap_last.delete();
    cap_count.delete();
    pop_cnt  = 0;
    done_cnt = 0;
  endtask

  // Run n cycles feeding from the source array and recording pops/accepts
  task automatic run_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      pixel_valid_i = (src_idx < src_len);
      pixel_data_i  = (src_idx < src_len) ? src_data[src_idx] : 24'h0;
      pixel_last_i  = (src_idx < src_len) ? src_last[src_idx] : 1'b0;
      @(negedge clk_i);
      if (pixel_pop_o && !pixel_valid_i) begin
        checks++;
        fails++;
        $display("FAIL pop_without_valid: pop=%0b valid=%0b, required pop=0", pixel_pop_o, pixel_valid_i);
      end
      if (frame_done_o) done_cnt++;
      if (out_valid_o && out_accept_i) begin
        cap_data.push_back(out_data_o);
        cap_strb.push_back(out_strb_o);
        cap_last.push_back(out_last_o);
        cap_count.push_back(word_count_o);
        $display("word accepted: data=%08h strb=%h last=%0b count=%0d", out_data_o, out_strb_o, out_last_o, word_count_o);
      end
      if (pixel_pop_o) begin
        pop_cnt++;
        src_idx++;
      end
      @(posedge clk_i);
      #1;
    end
    pixel_valid_i = 1'b0;
    pixel_last_i  = 1'b0;
  endtask

  task automatic check_word(input string name, input int idx, input logic [31:0] d,
                            input logic [3:0] s, input logic l);
    checks++;
    if (cap_data.size() <= idx) begin
      fails++;
      $display("FAIL %s_present: got %0d words, required more than %0d", name, cap_data.size(), idx);
    end else if (cap_data[idx] !== d || cap_strb[idx] !== s || cap_last[idx] !== l) begin
      fails++;
      $display("FAIL %s: got data=%08h strb=%h last=%0b, required data=%08h strb=%h last=%0b",
               name, cap_data[idx], cap_strb[idx], cap_last[idx], d, s, l);
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; flush_i = 1'b0; out_accept_i = 1'b0;
    pixel_valid_i = 1'b1; pixel_data_i = 24'hFFFFFF; pixel_last_i = 1'b0;
    src_len = 0; src_idx = 0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    checks++;
    if (pixel_pop_o !== 1'b0) begin fails++; $display("FAIL reset_pop: got %0b, required 0", pixel_pop_o); end
    checks++;
    if ({out_valid_o, out_strb_o, out_last_o, frame_done_o} !== 7'd0 || out_data_o !== 32'h0 || word_count_o !== 16'h0) begin
      fails++;
      $display("FAIL reset_outputs: got valid=%0b data=%08h strb=%h last=%0b done=%0b count=%0d, required all 0",
               out_valid_o, out_data_o, out_strb_o, out_last_o, frame_done_o, word_count_o);
    end
    pixel_valid_i = 1'b0;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
  endtask

  task automatic test_pair();
    clear_caps();
    out_accept_i = 1'b1;
    src_data[0] = 24'hFF0000; src_last[0] = 1'b0;
    src_data[1] = 24'h00FF00; src_last[1] = 1'b0;
    src_len = 2; src_idx = 0;
    run_cycles(4);
    check_word("pair_word", 0, 32'h07E0F800, 4'hF, 1'b0);
    checks++;
    if (cap_data.size() != 1) begin fails++; $display("FAIL pair_word_count: got %0d words, required 1", cap_data.size()); end
    checks++;
    if (word_count_o !== 16'd1) begin fails++; $display("FAIL pair_counter: got %0d, required 1", word_count_o); end
  endtask

  task automatic test_frame_end();
    clear_caps();
    out_accept_i = 1'b1;
    src_data[0] = 24'hFFFFFF; src_last[0] = 1'b0;
    src_data[1] = 24'h000000; src_last[1] = 1'b0;
    src_data[2] = 24'h0000FF; src_last[2] = 1'b1;
    src_len = 3; src_idx = 0;
    run_cycles(6);
    check_word("frame_word2", 0, 32'h0000FFFF, 4'hF, 1'b0);
    check_word("frame_word3", 1, 32'h0000001F, 4'h3, 1'b1);
    checks++;
    if (cap_count.size() < 2 || cap_count[0] !== 16'd1 || cap_count[1] !== 16'd2) begin
      fails++; $display("FAIL frame_counts: got %0d words, required counts 1 then 2 at accept", cap_count.size());
    end
    checks++;
    if (done_cnt != 1) begin fails++; $display("FAIL frame_done_pulses: got %0d, required 1", done_cnt); end
    checks++;
    if (word_count_o !== 16'd0) begin fails++; $display("FAIL frame_counter_clear: got %0d, required 0", word_count_o); end
  endtask

  task automatic test_backpressure();
    int unstable;
    clear_caps();
    unstable = 0;
    out_accept_i = 1'b0;
    load_src(1, 8, 1'b1);
    for (int c = 0; c < 10; c++) begin
      run_cycles(1);
      if (out_valid_o && out_data_o !== 32'h10420821) unstable++;
    end
    checks++;
    if (pop_cnt != 3) begin fails++; $display("FAIL stall_pops: got %0d, required 3", pop_cnt); end
    checks++;
    if (unstable != 0 || out_valid_o !== 1'b1) begin
      fails++; $display("FAIL stall_stable: got %0d changes valid=%0b, required 0 changes valid=1", unstable, out_valid_o);
    end
    out_accept_i = 1'b1;
    run_cycles(8);
    check_word("bp_word0", 0, 32'h10420821, 4'hF, 1'b0);
    check_word("bp_word1", 1, 32'h20841863, 4'hF, 1'b0);
    check_word("bp_word2", 2, 32'h30C628A5, 4'hF, 1'b0);
    check_word("bp_word3", 3, 32'h410838E7, 4'hF, 1'b1);
    checks++;
    if (pop_cnt != 8 || cap_data.size() != 4) begin
      fails++; $display("FAIL bp_totals: got pops=%0d words=%0d, required 8 and 4", pop_cnt, cap_data.size());
    end
  endtask

  task automatic test_round();
    clear_caps();
    out_accept_i = 1'b1;
    src_data[0] = 24'h070305; src_last[0] = 1'b0;
    src_data[1] = 24'hFFFFFF; src_last[1] = 1'b1;
    src_len = 2; src_idx = 0;
    run_cycles(5);
`ifdef JPEG_RGB565_ROUND_EN
    check_word("round_word", 0, 32'hFFFF0821, 4'hF, 1'b1);
`else
    check_word("trunc_word", 0, 32'hFFFF0000, 4'hF, 1'b1);
`endif
  endtask

  task automatic test_flush();
    clear_caps();
    out_accept_i = 1'b1;
    load_src(1, 2, 1'b0);
    run_cycles(4);
    out_accept_i = 1'b0;
    load_src(3, 3, 1'b0);
    run_cycles(5);
    checks++;
    if (out_valid_o !== 1'b1 || word_count_o !== 16'd1 || pop_cnt != 5) begin
      fails++; $display("FAIL flush_setup: got valid=%0b count=%0d pops=%0d, required 1 1 5", out_valid_o, word_count_o, pop_cnt);
    end
    flush_i = 1'b1; out_accept_i = 1'b1;
    pixel_valid_i = 1'b1; pixel_data_i = px(9); pixel_last_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (pixel_pop_o !== 1'b0) begin fails++; $display("FAIL flush_pop: got %0b, required 0", pixel_pop_o); end
    @(posedge clk_i); #1;
    flush_i = 1'b0; pixel_valid_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (out_valid_o !== 1'b0 || word_count_o !== 16'd0) begin
      fails++; $display("FAIL flush_clear: got valid=%0b count=%0d, required 0 0", out_valid_o, word_count_o);
    end
    @(posedge clk_i); #1;
    clear_caps();
    load_src(6, 2, 1'b1);
    run_cycles(5);
    check_word("flush_fresh", 0, 32'h38E730C6, 4'hF, 1'b1);
    checks++;
    if (cap_data.size() != 1) begin fails++; $display("FAIL flush_words: got %0d, required 1", cap_data.size()); end
  endtask

  task automatic test_async_reset();
    clear_caps();
    out_accept_i = 1'b0;
    load_src(1, 3, 1'b0);
    run_cycles(5);
    pixel_valid_i = 1'b1; pixel_data_i = px(9); pixel_last_i = 1'b1;
    #2;
    rst_ni = 1'b0;
    #1;
    checks++;
    if (out_valid_o !== 1'b0 || out_data_o !== 32'h0 || out_strb_o !== 4'h0 || out_last_o !== 1'b0 ||
        word_count_o !== 16'h0 || frame_done_o !== 1'b0 || pixel_pop_o !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: got valid=%0b data=%08h strb=%h last=%0b count=%0d pop=%0b, required all 0",
               out_valid_o, out_data_o, out_strb_o, out_last_o, word_count_o, pixel_pop_o);
    end
    pixel_valid_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    out_accept_i = 1'b1;
    load_src(4, 2, 1'b1);
    run_cycles(5);
    check_word("restart_word", 0, 32'h28A52084, 4'hF, 1'b1);
  endtask

  initial begin
    flush_i = 1'b0; out_accept_i = 1'b0;
    pixel_valid_i = 1'b0; pixel_data_i = 24'h0; pixel_last_i = 1'b0;
    src_len = 0; src_idx = 0;
    test_reset();
    test_pair();
    test_frame_end();
    test_backpressure();
    test_round();
    test_flush();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
